// File: rtl/eth_tx_fcs_framer.sv
// Ethernet TX framer: preamble, SFD, payload, zero pad and FCS.
// Drives the byte-feed port of an external augmented crc32 engine.
module eth_tx_fcs_framer #(
  parameter int MIN_PAYLOAD  = 60,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        crc_reset,
  output logic        crc_we,
  output logic [7:0]  crc_byte,
  input  logic [31:0] crc_value,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, DATA, PAD, FLUSH, FCS
  } state_t;

  localparam bit         HAS_PRE  = (PREAMBLE_LEN > 0);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [11:0] MIN_W   = 12'(MIN_PAYLOAD);

  state_t      state_q, state_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [10:0] bcnt_q, bcnt_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [31:0] fcs_q, fcs_d;

  logic [11:0] bcnt_inc;
  logic [10:0] bcnt_sat;
  logic [7:0]  inv_mask;
  logic [31:0] fcs_w;
  logic [31:0] fcs_src;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) bitrev8[i] = v[7-i];
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    for (int i = 0; i < 32; i++) bitrev32[i] = v[31-i];
  endfunction

  // First four fed bytes are inverted so the augmented engine
  // behaves like an all-ones preset CRC.
  always_comb begin
    bcnt_inc = {1'b0, bcnt_q} + 12'd1;
    bcnt_sat = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
    inv_mask = (bcnt_q < 11'd4) ? 8'hFF : 8'h00;
    fcs_w    = ~bitrev32(crc_value);
    fcs_src  = (fcnt_q == 2'd0) ? fcs_w : fcs_q;
  end

  // Next-state, counters and all framer outputs.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    bcnt_d    = bcnt_q;
    fcnt_d    = fcnt_q;
    fcs_d     = fcs_q;
    in_ready  = 1'b0;
    out_data  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    crc_reset = 1'b0;
    crc_we    = 1'b0;
    crc_byte  = 8'h00;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        pcnt_d = 8'd0;
        if (in_valid) state_d = HAS_PRE ? PRE : SFD;
      end
      PRE: begin
        out_valid = 1'b1;
        out_data  = 8'h55;
        if (out_ready) begin
          if (pcnt_q == PRE_LAST) begin
            pcnt_d  = 8'd0;
            state_d = SFD;
          end else begin
            pcnt_d = pcnt_q + 8'd1;
          end
        end
      end
      SFD: begin
        out_valid = 1'b1;
        out_data  = 8'hD5;
        crc_reset = 1'b1;
        if (out_ready) begin
          bcnt_d  = 11'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        out_data  = in_data;
        out_valid = in_valid;
        in_ready  = out_ready;
        if (in_valid && out_ready) begin
          crc_we   = 1'b1;
          crc_byte = bitrev8(in_data) ^ inv_mask;
          bcnt_d   = bcnt_sat;
          if (in_last) begin
            fcnt_d  = 2'd0;
            state_d = (bcnt_inc < MIN_W) ? PAD : FLUSH;
          end
        end
      end
      PAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          crc_we   = 1'b1;
          crc_byte = inv_mask;
          bcnt_d   = bcnt_sat;
          if (bcnt_inc == MIN_W) begin
            fcnt_d  = 2'd0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        crc_we = 1'b1;
        fcnt_d = fcnt_q + 2'd1;
        if (fcnt_q == 2'd3) state_d = FCS;
      end
      FCS: begin
        out_valid = 1'b1;
        out_last  = (fcnt_q == 2'd3);
        if (fcnt_q == 2'd0) fcs_d = fcs_w;
        case (fcnt_q)
          2'd0:    out_data = fcs_src[7:0];
          2'd1:    out_data = fcs_src[15:8];
          2'd2:    out_data = fcs_src[23:16];
          default: out_data = fcs_src[31:24];
        endcase
        if (out_ready) begin
          fcnt_d = fcnt_q + 2'd1;
          if (fcnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pcnt_q  <= 8'd0;
      bcnt_q  <= 11'd0;
      fcnt_q  <= 2'd0;
      fcs_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
      fcs_q   <= fcs_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_framer.sv
// Bench for eth_tx_fcs_framer: two instances (no pad / default pad)
// each feeding its own model of the external crc32 engine.
module tb_eth_tx_fcs_framer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [7:0] in_data;
  logic in_valid, in_last, out_ready, sel;

  logic a_in_valid, a_in_ready, a_out_valid, a_out_last;
  logic a_crc_reset, a_crc_we, a_busy;
  logic [7:0] a_out_data, a_crc_byte;
  logic [31:0] crc_a;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_last;
  logic b_crc_reset, b_crc_we, b_busy;
  logic [7:0] b_out_data, b_crc_byte;
  logic [31:0] crc_b;

  logic in_ready, out_valid, out_last, crc_reset, crc_we, busy;
  logic [7:0] out_data, crc_byte;

  assign a_in_valid = in_valid & ~sel;
  assign b_in_valid = in_valid & sel;
  assign in_ready  = sel ? b_in_ready  : a_in_ready;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign out_last  = sel ? b_out_last  : a_out_last;
  assign out_data  = sel ? b_out_data  : a_out_data;
  assign crc_reset = sel ? b_crc_reset : a_crc_reset;
  assign crc_we    = sel ? b_crc_we    : a_crc_we;
  assign crc_byte  = sel ? b_crc_byte  : a_crc_byte;
  assign busy      = sel ? b_busy      : a_busy;

  eth_tx_fcs_framer #(.MIN_PAYLOAD(0), .PREAMBLE_LEN(7)) u_a (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(a_in_valid), .in_last(in_last),
    .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_last(a_out_last),
    .out_ready(out_ready), .crc_reset(a_crc_reset),
    .crc_we(a_crc_we), .crc_byte(a_crc_byte),
    .crc_value(crc_a), .busy(a_busy)
  );

  eth_tx_fcs_framer #(.MIN_PAYLOAD(60), .PREAMBLE_LEN(7)) u_b (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(b_in_valid), .in_last(in_last),
    .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_last(b_out_last),
    .out_ready(out_ready), .crc_reset(b_crc_reset),
    .crc_we(b_crc_we), .crc_byte(b_crc_byte),
    .crc_value(crc_b), .busy(b_busy)
  );

  // Augmented MSB-first CRC-32 engine step, polynomial 0x04C11DB7.
  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [7:0] b);
    logic msb;
    for (int i = 7; i >= 0; i--) begin
      msb = c[31];
      c = {c[30:0], b[i]};
      if (msb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_a <= 32'd0;
    else if (a_crc_reset) crc_a <= 32'd0;
    else if (a_crc_we) crc_a <= crc_step(crc_a, a_crc_byte);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_b <= 32'd0;
    else if (b_crc_reset) crc_b <= 32'd0;
    else if (b_crc_we) crc_b <= crc_step(crc_b, b_crc_byte);
  end

  logic [7:0] stim_d[$];
  bit         stim_l[$];
  logic [7:0] cap_d[$], exp_d[$], ref_d[$];
  bit         cap_l[$], exp_l[$];
  int         cap_c[$];
  int we_cnt, rst_rise, stall_err, busy_err;
  bit tout;
  int errors = 0;
  int checks = 0;

  // Reference CRC-32 (reflected table-less form) over payload + pad.
  function automatic logic [31:0] crc_std(int st, int n, int minp);
    logic [31:0] c;
    logic [7:0] b;
    int tot;
    tot = (n < minp) ? minp : n;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < tot; k++) begin
      b = (k < n) ? stim_d[st+k] : 8'h00;
      c = c ^ {24'd0, b};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_exp(int st, int n, int minp);
    int tot;
    logic [31:0] c;
    tot = (n < minp) ? minp : n;
    c = crc_std(st, n, minp);
    for (int k = 0; k < 7; k++) begin
      exp_d.push_back(8'h55); exp_l.push_back(1'b0);
    end
    exp_d.push_back(8'hD5); exp_l.push_back(1'b0);
    for (int k = 0; k < tot; k++) begin
      exp_d.push_back((k < n) ? stim_d[st+k] : 8'h00);
      exp_l.push_back(1'b0);
    end
    for (int j = 0; j < 4; j++) begin
      exp_d.push_back(c[8*j +: 8]);
      exp_l.push_back(j == 3);
    end
  endtask

  function automatic int seq_diff();
    int d;
    d = 0;
    if (cap_d.size() != exp_d.size()) return 1000;
    for (int i = 0; i < cap_d.size(); i++)
      if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) d++;
    return d;
  endfunction

  task automatic new_stim();
    stim_d.delete(); stim_l.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  // Cycle driver/collector: inputs change on negedge, outputs
  // sampled 2ns later, well away from the rising edge.
  task automatic run(input bit gaps, input bit thr,
                     input int nlast, input int abort_at);
    int idx, cyc, nl;
    bit prev_stall, chk_busy, prev_rst, done;
    logic [7:0] stall_d;
    idx = 0; cyc = 0; nl = 0;
    prev_stall = 0; chk_busy = 0; prev_rst = 0; done = 0;
    stall_d = 8'h00;
    cap_d.delete(); cap_l.delete(); cap_c.delete();
    we_cnt = 0; rst_rise = 0; stall_err = 0; busy_err = 0; tout = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = (idx < stim_d.size()) &&
                 (!gaps || $urandom_range(0, 2) != 0);
      in_data  = in_valid ? stim_d[idx] : 8'h00;
      in_last  = in_valid ? stim_l[idx] : 1'b0;
      out_ready = thr ? ($urandom_range(0, 1) != 0) : 1'b1;
      #2;
      if (chk_busy && busy !== 1'b0) busy_err++;
      if (chk_busy && nl == nlast) done = 1;
      chk_busy = 0;
      if (crc_we === 1'b1) we_cnt++;
      if (crc_reset === 1'b1 && !prev_rst) rst_rise++;
      prev_rst = (crc_reset === 1'b1);
      if (prev_stall && (out_valid !== 1'b1 || out_data !== stall_d))
        stall_err++;
      prev_stall = (out_valid === 1'b1) && !out_ready && !gaps;
      stall_d = out_data;
      if (in_valid && in_ready === 1'b1) idx++;
      if (out_valid === 1'b1 && out_ready) begin
        cap_d.push_back(out_data);
        cap_l.push_back(out_last === 1'b1);
        cap_c.push_back(cyc);
        if (out_last === 1'b1) begin
          nl++;
          chk_busy = 1;
        end
      end
      cyc++;
      if (cyc >= 4000) begin tout = 1; done = 1; end
      if (abort_at > 0 && cyc >= abort_at) done = 1;
    end
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    reset_n = 1'b0; sel = 1'b0;
    in_valid = 0; in_last = 0; in_data = 8'h00; out_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    ctl = {out_valid, out_last, in_ready, crc_we, crc_reset, busy, 1'b0};
    checks++;
    if (ctl !== 7'd0) begin
      errors++; $display("FAIL reset_ctl_a: got %b want 0", ctl);
    end
    checks++;
    if (out_data !== 8'h00 || crc_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_bytes_a: got %h/%h want 00/00", out_data, crc_byte);
    end
    sel = 1'b1;
    #1;
    ctl = {out_valid, out_last, in_ready, crc_we, crc_reset, busy, 1'b0};
    checks++;
    if (ctl !== 7'd0 || out_data !== 8'h00) begin
      errors++; $display("FAIL reset_ctl_b: got %b/%h want 0/00", ctl, out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #2;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_check_string();
    logic [7:0] want[4];
    logic [7:0] s[9];
    want = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    sel = 1'b0;
    new_stim();
    for (int i = 0; i < 9; i++) begin
      stim_d.push_back(s[i]); stim_l.push_back(i == 8);
    end
    build_exp(0, 9, 0);
    run(0, 0, 1, 0);
    checks++;
    if (tout || seq_diff() != 0) begin
      errors++; $display("FAIL chk_seq: got %0d diffs want 0 (len %0d want 21)", seq_diff(), cap_d.size());
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (cap_d.size() != 21 || cap_d[17+j] !== want[j]) begin
        errors++;
        $display("FAIL chk_fcs%0d: got %h want %h", j,
                 (cap_d.size() == 21) ? cap_d[17+j] : 8'hXX, want[j]);
      end
    end
    checks++;
    if (cap_c.size() != 21 || cap_c[17] - cap_c[16] != 5) begin
      errors++; $display("FAIL chk_flush_gap: got size %0d want gap 5", cap_c.size());
    end
    checks++;
    if (we_cnt !== 13 || busy_err !== 0 || rst_rise !== 1) begin
      errors++;
      $display("FAIL chk_we_busy: we=%0d busy_err=%0d rst=%0d want 13/0/1", we_cnt, busy_err, rst_rise);
    end
  endtask

  task automatic test_padding();
    sel = 1'b1;
    new_stim();
    for (int i = 0; i < 14; i++) begin
      stim_d.push_back(8'(i * 7 + 3)); stim_l.push_back(i == 13);
    end
    build_exp(0, 14, 60);
    run(0, 0, 1, 0);
    checks++;
    if (tout || cap_d.size() != 72) begin
      errors++; $display("FAIL pad_len: got %0d want 72", cap_d.size());
    end
    checks++;
    if (seq_diff() != 0) begin
      errors++; $display("FAIL pad_seq: got %0d diffs want 0", seq_diff());
    end
    checks++;
    if (we_cnt !== 64 || busy_err !== 0) begin
      errors++; $display("FAIL pad_we: got %0d/%0d want 64/0", we_cnt, busy_err);
    end
  endtask

  task automatic test_throttle();
    int d;
    sel = 1'b1;
    new_stim();
    for (int i = 0; i < 64; i++) begin
      stim_d.push_back(8'(i * 37 + 5)); stim_l.push_back(i == 63);
    end
    build_exp(0, 64, 60);
    run(0, 0, 1, 0);
    ref_d = cap_d;
    run(0, 1, 1, 0);
    d = 0;
    if (cap_d.size() != ref_d.size()) d = 1000;
    else for (int i = 0; i < cap_d.size(); i++) if (cap_d[i] !== ref_d[i]) d++;
    checks++;
    if (tout || d != 0) begin
      errors++; $display("FAIL thr_vs_free: got %0d diffs want 0", d);
    end
    checks++;
    if (seq_diff() != 0) begin
      errors++; $display("FAIL thr_seq: got %0d diffs want 0", seq_diff());
    end
    checks++;
    if (stall_err !== 0 || we_cnt !== 68) begin
      errors++; $display("FAIL thr_stall: stall_err=%0d we=%0d want 0/68", stall_err, we_cnt);
    end
  endtask

  task automatic test_gaps();
    sel = 1'b0;
    new_stim();
    for (int i = 0; i < 20; i++) begin
      stim_d.push_back(8'(255 - i * 11)); stim_l.push_back(i == 19);
    end
    build_exp(0, 20, 0);
    run(1, 0, 1, 0);
    checks++;
    if (tout || we_cnt !== 24) begin
      errors++; $display("FAIL gap_we: got %0d want 24", we_cnt);
    end
    checks++;
    if (seq_diff() != 0) begin
      errors++; $display("FAIL gap_seq: got %0d diffs want 0", seq_diff());
    end
  endtask

  task automatic test_abort();
    logic [5:0] ctl;
    sel = 1'b1;
    new_stim();
    for (int i = 0; i < 30; i++) begin
      stim_d.push_back(8'(i + 100)); stim_l.push_back(i == 29);
    end
    run(0, 0, 1, 15);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL abort_pre: busy=%b valid=%b want 1/1", busy, out_valid);
    end
    #1 reset_n = 1'b0;
    #1;
    ctl = {out_valid, out_last, in_ready, crc_we, crc_reset, busy};
    checks++;
    if (ctl !== 6'd0 || out_data !== 8'h00 || crc_byte !== 8'h00) begin
      errors++; $display("FAIL abort_async: got %b/%h/%h want 0/00/00", ctl, out_data, crc_byte);
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    new_stim();
    for (int i = 0; i < 10; i++) begin
      stim_d.push_back(8'(i * 29 + 17)); stim_l.push_back(i == 9);
    end
    build_exp(0, 10, 60);
    run(0, 0, 1, 0);
    checks++;
    if (tout || seq_diff() != 0) begin
      errors++; $display("FAIL abort_next_seq: got %0d diffs want 0", seq_diff());
    end
    checks++;
    if (we_cnt !== 64) begin
      errors++; $display("FAIL abort_next_we: got %0d want 64", we_cnt);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    new_stim();
    for (int i = 0; i < 5; i++) begin
      stim_d.push_back(8'(i * 3 + 0)); stim_l.push_back(i == 4);
    end
    for (int i = 0; i < 6; i++) begin
      stim_d.push_back(8'(200 - i)); stim_l.push_back(i == 5);
    end
    build_exp(0, 5, 0);
    build_exp(5, 6, 0);
    run(0, 0, 2, 0);
    checks++;
    if (tout || seq_diff() != 0) begin
      errors++; $display("FAIL b2b_seq: got %0d diffs want 0", seq_diff());
    end
    // One IDLE cycle separates the last FCS byte and the next preamble.
    checks++;
    if (cap_c.size() != 35 || cap_c[17] - cap_c[16] != 2) begin
      errors++; $display("FAIL b2b_gap: got size %0d want gap 2", cap_c.size());
    end
    checks++;
    if (rst_rise !== 2) begin
      errors++; $display("FAIL b2b_crc_reset: got %0d want 2", rst_rise);
    end
    checks++;
    if (we_cnt !== 19 || busy_err !== 0) begin
      errors++; $display("FAIL b2b_we: got %0d/%0d want 19/0", we_cnt, busy_err);
    end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_padding();
    test_throttle();
    test_gaps();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
